// File: rtl/phv_out_fifo.sv
// ============================================================================
//  Module      : phv_out_fifo
//  Description : Output PHV buffer between the last match-action stage and the
//                deparser. First-word-fall-through FIFO with an early
//                (almost-full) ready, plus overflow drop counting and a sticky
//                error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module phv_out_fifo #(
  parameter int PHV_LEN      = 1024,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int AFULL_MARGIN = 3
) (
  input  logic                axis_clk,
  input  logic                areset,
  input  logic [PHV_LEN-1:0]  phv_in,
  input  logic                phv_in_valid,
  output logic                phv_fifo_ready,
  output logic [PHV_LEN-1:0]  phv_out,
  output logic                phv_out_valid,
  input  logic                phv_out_ready,
  output logic [ADDR_W:0]     occupancy,
  output logic                overflow_err,
  output logic [15:0]         drop_cnt
);

  // Occupancy thresholds expressed at the occupancy counter width.
  localparam logic [ADDR_W:0] FULL_LVL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W+1)'(DEPTH - AFULL_MARGIN);
  localparam logic [15:0]     CNT_MAX   = 16'hFFFF;

  logic [PHV_LEN-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W:0]    occupancy_next;
  logic               pop;
  logic               push;
  logic               drop;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop  = phv_out_valid & phv_out_ready;
  assign push = phv_in_valid & ((occupancy < FULL_LVL) | pop);
  assign drop = phv_in_valid & ~push;

  // Head of queue falls through straight from storage; no empty bypass.
  assign phv_out       = mem[rd_ptr];
  assign phv_out_valid = (occupancy != '0);

  // Next occupancy: simultaneous push and pop cancel out.
  always_comb begin
    occupancy_next = occupancy;
    case ({push, pop})
      2'b10:   occupancy_next = occupancy + 1'b1;
      2'b01:   occupancy_next = occupancy - 1'b1;
      default: occupancy_next = occupancy;
    endcase
  end

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge axis_clk) begin
    if (push) begin
      mem[wr_ptr] <= phv_in;
    end
  end

  // Pointers, occupancy and early ready; pointers wrap by natural overflow.
  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      occupancy      <= '0;
      phv_fifo_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occupancy      <= occupancy_next;
      // Drops early so PHVs already in flight upstream still find space.
      phv_fifo_ready <= (occupancy_next < AFULL_LVL);
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) begin
      overflow_err <= 1'b0;
      drop_cnt     <= '0;
    end else if (drop) begin
      overflow_err <= 1'b1;
      if (drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + 16'd1;
    end
  end

`ifndef SYNTHESIS
  // Structural invariants of the queue bookkeeping.
  always_ff @(posedge axis_clk) begin
    if (!areset) begin
      assert (occupancy <= FULL_LVL);
      assert (!(phv_out_valid && (occupancy == '0)));
      assert (!drop || ((occupancy == FULL_LVL) && !pop));
    end
  end
`endif

endmodule

`default_nettype wire
